// File: rtl/spi_arbiter_if.sv
// Signal bundle between two byte requesters, the arbiter and the SPI byte engine.
// The master modport is the arbiter's view; slave is the requesters/engine side.
interface spi_arbiter_if;
    logic       r0_req;
    logic       r1_req;
    logic       r0_hold;
    logic       r1_hold;
    logic [7:0] r0_tx;
    logic [7:0] r1_tx;
    logic [7:0] r0_rx;
    logic [7:0] r1_rx;
    logic       r0_ack;
    logic       r1_ack;
    logic [1:0] grant;
    logic       e_start;
    logic [7:0] e_tx;
    logic       e_busy;
    logic [7:0] e_rx;
    logic       spi_cs;

    modport master (
        input  r0_req, r1_req, r0_hold, r1_hold, r0_tx, r1_tx, e_busy, e_rx,
        output r0_rx, r1_rx, r0_ack, r1_ack, grant, e_start, e_tx, spi_cs
    );

    modport slave (
        output r0_req, r1_req, r0_hold, r1_hold, r0_tx, r1_tx, e_busy, e_rx,
        input  r0_rx, r1_rx, r0_ack, r1_ack, grant, e_start, e_tx, spi_cs
    );
endinterface

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of one SPI byte engine, with session
// hold, per-byte watchdog and an enforced idle gap after every acknowledged byte.
module spi_arbiter #(
    parameter int unsigned FIRST = 0,
    parameter int unsigned GAP   = 2,
    parameter int unsigned WDOG  = 4
) (
    input logic           clk,
    input logic           rst_n,
    spi_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StOwned, StWait, StGap} state_e;

    localparam logic       FirstSel = (FIRST != 0);
    localparam logic [3:0] GapLast  = 4'(GAP - 1);
    localparam logic [3:0] WdogLast = 4'(WDOG - 1);

    state_e     state_q;
    logic       owner_q, ptr_q, rdy_q, busy_seen_q;
    logic [3:0] cnt_q;
    logic [1:0] grant_q, ack_q;
    logic       e_start_q, cs_q;
    logic [7:0] e_tx_q, rx0_q, rx1_q;

    logic [1:0] req, hold, active;
    logic       other, idle_sel, done;
    logic [7:0] tx_own, done_rx;

    assign req      = {bus.r1_req, bus.r0_req};
    assign hold     = {bus.r1_hold, bus.r0_hold};
    assign active   = req | hold;
    assign other    = ~owner_q;
    assign idle_sel = (&active) ? ptr_q : active[1];
    assign tx_own   = owner_q ? bus.r1_tx : bus.r0_tx;

    // Byte finishes on a seen busy->idle edge, or on watchdog expiry if busy never rose.
    always_comb begin
        done    = 1'b0;
        done_rx = bus.e_rx;
        if (state_q == StWait) begin
            if (busy_seen_q) begin
                done = ~bus.e_busy;
            end else if (!bus.e_busy && cnt_q == WdogLast) begin
                done    = 1'b1;
                done_rx = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            ptr_q       <= FirstSel;
            rdy_q       <= 1'b0;
            busy_seen_q <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= 2'b00;
            ack_q       <= 2'b00;
            e_start_q   <= 1'b0;
            e_tx_q      <= 8'h00;
            rx0_q       <= 8'hFF;
            rx1_q       <= 8'hFF;
            cs_q        <= 1'b1;
        end else begin
            // rdy_q holds off granting on the first edge after reset release.
            rdy_q     <= 1'b1;
            e_start_q <= 1'b0;
            ack_q     <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (rdy_q && (|active)) begin
                        owner_q <= idle_sel;
                        grant_q <= {idle_sel, ~idle_sel};
                        cs_q    <= ~hold[idle_sel];
                        state_q <= StOwned;
                    end else begin
                        cs_q <= 1'b1;
                    end
                end
                StOwned: begin
                    cs_q <= ~hold[owner_q];
                    if (req[owner_q]) begin
                        e_start_q   <= 1'b1;
                        e_tx_q      <= tx_own;
                        cnt_q       <= '0;
                        busy_seen_q <= 1'b0;
                        state_q     <= StWait;
                    end else if (!hold[owner_q]) begin
                        grant_q <= 2'b00;
                        ptr_q   <= other;
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (done) begin
                        if (owner_q) rx1_q <= done_rx;
                        else         rx0_q <= done_rx;
                        ack_q   <= {owner_q, ~owner_q};
                        cnt_q   <= '0;
                        state_q <= StGap;
                    end else begin
                        if (bus.e_busy)   busy_seen_q <= 1'b1;
                        if (!busy_seen_q) cnt_q       <= cnt_q + 4'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        state_q <= StOwned;
                        if (!hold[owner_q] && active[other]) begin
                            owner_q <= other;
                            grant_q <= {other, ~other};
                            ptr_q   <= ~ptr_q;
                            cs_q    <= ~hold[other];
                        end else begin
                            cs_q <= ~hold[owner_q];
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.r0_ack  = ack_q[0];
    assign bus.r1_ack  = ack_q[1];
    assign bus.r0_rx   = rx0_q;
    assign bus.r1_rx   = rx1_q;
    assign bus.e_start = e_start_q;
    assign bus.e_tx    = e_tx_q;
    assign bus.spi_cs  = cs_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a byte-engine model answers tx ^ KEY after ENG_LEN
// busy cycles; expected bytes are queued at request time and checked on eStart/ack.
module tb_spi_arbiter;
    localparam int unsigned GAP     = 2;
    localparam int unsigned WDOG    = 4;
    localparam int          ENG_LEN = 16;
    localparam logic [7:0]  KEY     = 8'hD5;

    typedef struct {
        logic       who;
        logic [7:0] tx;
        logic [7:0] rx;
        bit         wd;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_arbiter_if bus ();

    spi_arbiter #(
        .FIRST (0),
        .GAP   (GAP),
        .WDOG  (WDOG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Engine model: busy for ENG_LEN cycles after a start, result presented as busy falls.
    logic [7:0] eng_rx   = 8'h00;
    logic [7:0] eng_tx   = 8'h00;
    logic       eng_busy = 1'b0;
    int         eng_cnt  = 0;
    bit         eng_dead = 1'b0;

    always @(posedge clk) begin
        if (bus.e_start && !eng_dead) begin
            eng_cnt  <= ENG_LEN;
            eng_busy <= 1'b1;
            eng_tx   <= bus.e_tx;
        end else if (eng_cnt == 1) begin
            eng_cnt  <= 0;
            eng_busy <= 1'b0;
            eng_rx   <= eng_tx ^ KEY;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    assign bus.e_busy = eng_busy;
    assign bus.e_rx   = eng_rx;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   st_cyc  = 0;
    bit   started = 1'b0;
    bit   sess    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic who, input logic [7:0] tx, input bit wd);
        exp_t e;
        e.who = who;
        e.tx  = tx;
        e.rx  = wd ? 8'hFF : (tx ^ KEY);
        e.wd  = wd;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (bus.r0_ack || bus.r1_ack) begin
            check("ack_expected", (sb.size() != 0) && started, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_who", {bus.r1_ack, bus.r0_ack}, e.who ? 2'b10 : 2'b01);
                check("rx", e.who ? bus.r1_rx : bus.r0_rx, e.rx);
                check("ack_grant", bus.grant, e.who ? 2'b10 : 2'b01);
                check("etx_stable", bus.e_tx, e.tx);
                if (e.wd) check("wdog_latency", cyc - st_cyc, WDOG);
            end
            started = 1'b0;
        end
        if (bus.e_start) begin
            check("estart_expected", (sb.size() != 0) && !started, 1);
            if (sb.size() != 0) begin
                check("etx", bus.e_tx, sb[0].tx);
                check("start_grant", bus.grant, sb[0].who ? 2'b10 : 2'b01);
            end
            started = 1'b1;
            st_cyc  = cyc;
        end
        if (sess) begin
            check("sess_grant", bus.grant, 2'b01);
            check("sess_cs", bus.spi_cs, 1'b0);
        end
    endtask

    // One clock: observe at the falling edge, then requesters react just after the rise.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
        cyc++;
        if (bus.r0_ack) bus.r0_req = 1'b0;
        if (bus.r1_ack) bus.r1_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic settle();
        repeat (6) tick();
        check("released_grant", bus.grant, 2'b00);
        check("released_cs", bus.spi_cs, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, bus.grant, 2'b00);
        check({tag, "_estart"}, bus.e_start, 1'b0);
        check({tag, "_etx"}, bus.e_tx, 8'h00);
        check({tag, "_acks"}, {bus.r1_ack, bus.r0_ack}, 2'b00);
        check({tag, "_rx"}, {bus.r1_rx, bus.r0_rx}, 16'hFFFF);
        check({tag, "_cs"}, bus.spi_cs, 1'b1);
    endtask

    initial begin
        bus.r0_req  = 1'b0;
        bus.r1_req  = 1'b0;
        bus.r0_hold = 1'b0;
        bus.r1_hold = 1'b0;
        bus.r0_tx   = 8'h00;
        bus.r1_tx   = 8'h00;

        // Reset values, with both requesters already asking.
        bus.r0_tx  = 8'h11;
        bus.r1_tx  = 8'h22;
        bus.r0_req = 1'b1;
        bus.r1_req = 1'b1;
        push(1'b0, 8'h11, 1'b0);
        push(1'b1, 8'h22, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // No grant on the first edge after release, grant to r0 on the second.
        tick();
        check("grant_edge1", bus.grant, 2'b00);
        tick();
        check("grant_edge2", bus.grant, 2'b01);
        wait_drain(200);
        settle();

        // Single byte 40 -> 95; r0 release moves the pointer to r1.
        bus.r0_tx  = 8'h40;
        bus.r0_req = 1'b1;
        push(1'b0, 8'h40, 1'b0);
        wait_drain(100);
        settle();

        // Simultaneous requests from idle: pointer now favours r1.
        bus.r0_tx  = 8'h44;
        bus.r1_tx  = 8'h33;
        bus.r0_req = 1'b1;
        bus.r1_req = 1'b1;
        push(1'b1, 8'h33, 1'b0);
        push(1'b0, 8'h44, 1'b0);
        wait_drain(200);
        settle();

        // r0 session of six bytes under hold; r1 waits until hold drops.
        bus.r0_hold = 1'b1;
        repeat (3) tick();
        check("hold_grant", bus.grant, 2'b01);
        check("hold_cs", bus.spi_cs, 1'b0);
        sess       = 1'b1;
        bus.r1_tx  = 8'h77;
        bus.r1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.r0_tx  = 8'h60 + 8'(i);
            bus.r0_req = 1'b1;
            push(1'b0, 8'h60 + 8'(i), 1'b0);
            wait_drain(100);
        end
        sess        = 1'b0;
        bus.r0_hold = 1'b0;
        push(1'b1, 8'h77, 1'b0);
        wait_drain(100);
        check("post_session_cs", bus.spi_cs, 1'b1);
        settle();

        // Dead engine: watchdog acknowledges r1 with FF.
        eng_dead   = 1'b1;
        bus.r1_tx  = 8'hFF;
        bus.r1_req = 1'b1;
        push(1'b1, 8'hFF, 1'b1);
        wait_drain(100);
        eng_dead = 1'b0;
        settle();

        // Reset in the middle of a byte aborts it; the late engine result is ignored.
        bus.r0_tx  = 8'h5C;
        bus.r0_req = 1'b1;
        push(1'b0, 8'h5C, 1'b0);
        for (int i = 0; i < 20 && !bus.e_start; i++) tick();
        check("abort_estart_seen", bus.e_start, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        bus.r0_req = 1'b0;
        sb.delete();
        started = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        check("no_ack_after_abort", {bus.r1_rx, bus.r0_rx}, 16'hFFFF);
        bus.r0_tx  = 8'h5D;
        bus.r0_req = 1'b1;
        push(1'b0, 8'h5D, 1'b0);
        wait_drain(100);
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
